spike_row_fetch: RTL and testbench

SPIKE_ROW_FETCH -- requirements
Module: spike_row_fetch

---
 rtl/snn_pkg.sv | 33 +++
 rtl/sr_skid_fifo.sv | 48 ++++
 rtl/spike_row_fetch.sv | 145 ++++++++++++++
 tb/tb_spike_row_fetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and parameter helpers for the spike row fetch path.
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Tag fields are sized for the widest supported config (IW <= 16, TIME_WIDTH <= 32).
  localparam int TAG_SRC_W  = 16;
  localparam int TAG_TIME_W = 32;

  typedef struct packed {
    logic                  last;
    logic [TAG_SRC_W-1:0]  src;
    logic [TAG_TIME_W-1:0] tstamp;
  } syn_tag_t;

  function automatic int calc_row_words(input int sr_depth, input int nr_depth);
    return sr_depth / nr_depth;
  endfunction

  function automatic int calc_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sr_skid_fifo.sv
// Two-entry FIFO buffering synapse words between the register read port and the updater.
module sr_skid_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
);

  logic [DW-1:0] r_mem [2];
  logic          r_rd_ptr;
  logic          r_wr_ptr;
  logic [1:0]    r_count;
  logic          w_do_pop;

  assign w_do_pop = i_pop & (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, w_do_pop};
    end
  end

  // Head entry is only rewritten once popped, so outputs hold while stalled.
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(i_push && (r_count == 2'd2)));

endmodule

// File: rtl/spike_row_fetch.sv
// Turns an accepted spike into a burst of synapse-row reads and streams the words out.
module spike_row_fetch
  import snn_pkg::*;
#(
  parameter  int NR_DEPTH   = 16,
  parameter  int SR_WIDTH   = 64,
  parameter  int SR_DEPTH   = 16384,
  parameter  int TIME_WIDTH = 8,
  localparam int ROW_WORDS  = calc_row_words(SR_DEPTH, NR_DEPTH),
  localparam int IW         = calc_log2(NR_DEPTH),
  localparam int AW         = calc_log2(SR_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  freeze,
  input  logic                  spk_valid,
  output logic                  spk_ready,
  input  logic [IW-1:0]         spk_index,
  input  logic [TIME_WIDTH-1:0] spk_time,
  output logic                  sr_rd_en,
  output logic [AW-1:0]         sr_rd_addr,
  input  logic [SR_WIDTH-1:0]   sr_rd_data,
  output logic                  syn_valid,
  input  logic                  syn_ready,
  output logic [SR_WIDTH-1:0]   syn_data,
  output logic [IW-1:0]         syn_src,
  output logic [TIME_WIDTH-1:0] syn_time,
  output logic                  syn_last,
  output logic                  busy
);

  localparam int RWL   = calc_log2(ROW_WORDS);
  localparam int CW    = (RWL > 0) ? RWL : 1;
  localparam int TAG_W = $bits(syn_tag_t);
  localparam int FW    = SR_WIDTH + TAG_W;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic [TIME_WIDTH-1:0] r_time;
  logic [CW-1:0]   r_cnt;
  logic            r_inflight;
  logic            r_infl_last;

  logic            w_pop;
  logic            w_rd_en;
  logic            w_accept;
  logic            w_last_rd;
  logic            w_fifo_valid;
  logic [1:0]      w_fifo_cnt;
  logic [2:0]      w_occ;
  syn_tag_t        w_push_tag;
  syn_tag_t        w_head_tag;
  logic [FW-1:0]   w_push_word;
  logic [FW-1:0]   w_head_word;
  logic            w_unused_tag;

  assign w_pop     = w_fifo_valid & syn_ready;
  // Slots committed after this cycle: buffered + returning read - word leaving now.
  assign w_occ     = {1'b0, w_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_last_rd = (r_cnt == CW'(ROW_WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    spk_ready   = 1'b0;
    w_rd_en     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        spk_ready = !freeze;
        if (spk_valid && !freeze) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!freeze && (w_occ < 3'd2)) begin
          w_rd_en = 1'b1;
          if (w_last_rd) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!r_inflight && ((w_fifo_cnt - {1'b0, w_pop}) == 2'd0)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_time      <= '0;
      r_cnt       <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_inflight  <= w_rd_en;
      r_infl_last <= w_rd_en & w_last_rd;
      if (w_accept) begin
        r_idx  <= spk_index;
        r_time <= spk_time;
        r_cnt  <= '0;
      end else if (w_rd_en && !w_last_rd) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign sr_rd_en   = w_rd_en;
  assign sr_rd_addr = (AW'(r_idx) << RWL) | AW'(r_cnt);

  // Owner fields stay put until the row fully drains, so they tag returning data directly.
  always_comb begin
    w_push_tag        = '0;
    w_push_tag.last   = r_infl_last;
    w_push_tag.src    = TAG_SRC_W'(r_idx);
    w_push_tag.tstamp = TAG_TIME_W'(r_time);
  end

  assign w_push_word = {sr_rd_data, w_push_tag};

  sr_skid_fifo #(.DW(FW)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_inflight),
    .i_data  (w_push_word),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_head_word),
    .o_count (w_fifo_cnt)
  );

  assign w_head_tag   = w_head_word[TAG_W-1:0];
  assign w_unused_tag = ^w_head_tag;

  assign syn_valid = w_fifo_valid;
  assign syn_data  = w_head_word[FW-1:TAG_W];
  assign syn_src   = w_head_tag.src[IW-1:0];
  assign syn_time  = w_head_tag.tstamp[TIME_WIDTH-1:0];
  assign syn_last  = w_fifo_valid & w_head_tag.last;
  assign busy      = (r_state != ST_IDLE) || (w_fifo_cnt != 2'd0);

endmodule

// File: tb/tb_spike_row_fetch.sv
// Scoreboard bench for spike_row_fetch with a memory model returning data = address.
module tb_spike_row_fetch;

  localparam int SW = 64;
  localparam int TW = 8;
  localparam int IW = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          freeze = 1'b0;
  logic          spk_valid = 1'b0;
  logic          syn_ready = 1'b0;
  logic [IW-1:0] spk_index = '0;
  logic [TW-1:0] spk_time = '0;
  logic          spk_ready, sr_rd_en, syn_valid, syn_last, busy;
  logic [AW-1:0] sr_rd_addr;
  logic [SW-1:0] sr_rd_data = '0;
  logic [SW-1:0] syn_data;
  logic [IW-1:0] syn_src;
  logic [TW-1:0] syn_time;

  spike_row_fetch #(.NR_DEPTH(16), .SR_WIDTH(SW), .SR_DEPTH(64), .TIME_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .freeze(freeze),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_index(spk_index), .spk_time(spk_time),
    .sr_rd_en(sr_rd_en), .sr_rd_addr(sr_rd_addr), .sr_rd_data(sr_rd_data),
    .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_data(syn_data),
    .syn_src(syn_src), .syn_time(syn_time), .syn_last(syn_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) sr_rd_data <= sr_rd_en ? SW'(sr_rd_addr) : 64'hDEAD_BEEF;

  typedef struct {
    logic [SW-1:0] data;
    logic [IW-1:0] src;
    logic [TW-1:0] tm;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // ---------------- monitor ----------------
  exp_t          e;
  bit            prv_stall = 1'b0;
  logic [SW-1:0] prv_data;
  logic [IW-1:0] prv_src;
  logic [TW-1:0] prv_time;
  logic          prv_last;
  int            occ = 0;
  bit            strm = 1'b0;
  int            strm_hs = 0, strm_k = 0, strm_kr = 0;
  int            pop23 = -1;
  int            ea;

  always @(negedge clk) begin
    if (prv_stall) begin
      chk("hold_valid", syn_valid, 1);
      chk("hold_data", syn_data, prv_data);
      chk("hold_src", syn_src, prv_src);
      chk("hold_time", syn_time, prv_time);
      chk("hold_last", syn_last, prv_last);
    end
    if (syn_valid && syn_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_word: got %0d expected none", syn_data);
      end else begin
        e = exp_q.pop_front();
        chk("syn_data", syn_data, e.data);
        chk("syn_src", syn_src, e.src);
        chk("syn_time", syn_time, e.tm);
        chk("syn_last", syn_last, e.last);
      end
      if (syn_data == 64'd23) pop23 = cyc;
      if (strm) begin
        chk("pop_cycle", cyc, strm_hs + 3 + strm_k);
        strm_k++;
      end
    end
    if (sr_rd_en && reset) begin
      if (addr_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_read: got %0d expected none", sr_rd_addr);
      end else begin
        ea = addr_q.pop_front();
        chk("rd_addr", sr_rd_addr, ea);
      end
      if (strm) begin
        chk("rd_cycle", cyc, strm_hs + 1 + strm_kr);
        strm_kr++;
      end
    end
    if (!reset) occ = 0;
    else begin
      occ = occ + int'(sr_rd_en) - int'(syn_valid && syn_ready);
      if (sr_rd_en) chk("outstanding_le2", (occ <= 2), 1);
    end
    prv_stall = reset && syn_valid && !syn_ready;
    prv_data  = syn_data;
    prv_src   = syn_src;
    prv_time  = syn_time;
    prv_last  = syn_last;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_words(input int base, input int n, input int src, input int tm, input bit has_last);
    exp_t x;
    for (int w = 0; w < n; w++) begin
      x.data = SW'(base + w);
      x.src  = IW'(src);
      x.tm   = TW'(tm);
      x.last = has_last && (w == n - 1);
      exp_q.push_back(x);
      addr_q.push_back(base + w);
    end
  endtask

  task automatic send_spike(input int idx, input int tm, output int hc);
    hc = -1;
    spk_valid = 1'b1;
    spk_index = IW'(idx);
    spk_time  = TW'(tm);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (spk_ready) begin
        hc = cyc;
        break;
      end
      tick();
    end
    if (hc < 0) fail_now("spike_accept");
    tick();
    spk_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (syn_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("wait_valid");
  endtask

  task automatic wait_rd(input int a);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sr_rd_en && (sr_rd_addr == AW'(a))) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) fail_now("wait_rd");
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && addr_q.size() == 0 && !busy) break;
      tick();
    end
    chk({nm, "_drained"}, (exp_q.size() == 0 && addr_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    int hc, hc2, nrd;
    // reset state, with freeze both high and low
    reset = 1'b0; freeze = 1'b1; syn_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_spk_ready_frozen", spk_ready, 0);
    chk("rst_rd_en", sr_rd_en, 0);
    chk("rst_syn_valid", syn_valid, 0);
    chk("rst_syn_last", syn_last, 0);
    chk("rst_busy", busy, 0);
    tick(); freeze = 1'b0;
    @(negedge clk);
    chk("rst_spk_ready", spk_ready, 1);
    tick(); reset = 1'b1;
    tick();

    // streaming row, latency and no-bubble timing
    expect_words(12, 4, 3, 7, 1'b1);
    strm_k = 0; strm_kr = 0;
    send_spike(3, 7, hc);
    strm_hs = hc; strm = 1'b1;
    drain("row3");
    strm = 1'b0;

    // consumer stall for 5 cycles
    syn_ready = 1'b0;
    expect_words(12, 4, 3, 7, 1'b1);
    send_spike(3, 7, hc);
    wait_valid();
    nrd = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        @(negedge clk);
      end
      if (sr_rd_en) nrd++;
    end
    chk("stall_reads", nrd, 0);
    tick(); syn_ready = 1'b1;
    drain("stall");

    // freeze after the second read
    expect_words(0, 4, 0, 1, 1'b1);
    send_spike(0, 1, hc);
    wait_rd(1);
    for (int k = 0; k < 4; k++) begin
      tick(); freeze = 1'b1;
      @(negedge clk);
      chk("frz_rd_en", sr_rd_en, 0);
      chk("frz_spk_ready", spk_ready, 0);
    end
    tick(); freeze = 1'b0;
    drain("freeze");

    // back-to-back spikes with valid held
    expect_words(20, 4, 5, 2, 1'b1);
    expect_words(24, 4, 6, 3, 1'b1);
    pop23 = -1;
    send_spike(5, 2, hc);
    send_spike(6, 3, hc2);
    chk("spk6_after_w23", (pop23 >= 0 && hc2 > pop23), 1);
    drain("b2b");

    // reset mid-row: only word 8 escapes, word 9 is discarded
    begin
      exp_t x;
      x.data = 64'd8; x.src = 4'd2; x.tm = 8'd4; x.last = 1'b0;
      exp_q.push_back(x);
      addr_q.push_back(8);
      addr_q.push_back(9);
    end
    send_spike(2, 4, hc);
    wait_rd(9);
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_syn_valid", syn_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rd_en", sr_rd_en, 0);
    chk("mid_rst_spk_ready", spk_ready, 1);
    chk("mid_rst_addr_q", addr_q.size(), 0);
    tick();
    expect_words(4, 4, 1, 5, 1'b1);
    send_spike(1, 5, hc);
    drain("after_rst");

    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
